soc_bus_6502: RTL

//  Parametrised memory-map fabric between cpu_65c02 and NSLOT peripheral slots.

---
 rtl/soc_bus_6502.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/soc_bus_6502.sv
// soc_bus_6502: memory-map fabric between the 65C02 core and NSLOT peripheral
// slots. Decodes the address page, paces the CPU through fixed or slave-driven
// wait states, returns the slave's registered read data, and flags unmapped or
// timed-out accesses with a sticky fault that holds the offending address.
module soc_bus_6502 #(
  parameter int                           NSLOT     = 4,
  parameter int                           PAGE_BITS = 4,
  parameter logic [NSLOT*PAGE_BITS-1:0]   SLOT_BASE = {4'hf, 4'h2, 4'h1, 4'h0},
  parameter logic [NSLOT*3-1:0]           SLOT_WAIT = {3'd0, 3'd1, 3'd0, 3'd0},
  parameter int                           TIMEOUT   = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [15:0]             cpu_ab,
  input  logic                    cpu_we,
  input  logic [7:0]              cpu_do,
  output logic [7:0]              cpu_di,
  output logic                    cpu_rdy,
  output logic [NSLOT-1:0]        slv_cs,
  output logic                    slv_we,
  output logic [15-PAGE_BITS:0]   slv_addr,
  output logic [7:0]              slv_wdata,
  input  logic [NSLOT*8-1:0]      slv_rdata,
  input  logic [NSLOT-1:0]        slv_ready,
  output logic                    fault,
  output logic [15:0]             fault_addr,
  input  logic                    fault_clr
);

  // Slot select encoding: 0..NSLOT-1 are slots, NSLOT means "no slot".
  localparam int               SELW     = $clog2(NSLOT + 1);
  localparam logic [SELW-1:0]  SEL_MISS = SELW'(NSLOT);
  localparam logic [7:0]       CNT_LAST = 8'(TIMEOUT - 1);
  localparam logic [2:0]       WAIT_PACED = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_PACE = 2'd2
  } state_t;

  state_t               state, state_next;
  logic [7:0]           cnt, cnt_next;
  logic [SELW-1:0]      sel_q;

  logic [PAGE_BITS-1:0] page;
  logic                 hit;
  logic [SELW-1:0]      hit_idx;
  logic [NSLOT-1:0]     hit_onehot;
  logic [2:0]           hit_wait;
  logic                 hit_ready;

  logic                 rdy;
  logic                 cs_en;
  logic                 we_en;
  logic                 timeout;
  logic                 fault_set;

  assign page      = cpu_ab[15 -: PAGE_BITS];
  assign slv_addr  = cpu_ab[15-PAGE_BITS:0];
  assign slv_wdata = cpu_do;
  assign cpu_rdy   = rdy;
  assign slv_we    = we_en;
  assign slv_cs    = cs_en ? hit_onehot : '0;
  assign fault_set = !reset && (!hit || timeout);

  // Page decode; scanning from the top lets the lowest matching slot win.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = SEL_MISS;
    hit_onehot = '0;
    hit_wait   = 3'd0;
    hit_ready  = 1'b0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (page == SLOT_BASE[i*PAGE_BITS +: PAGE_BITS]) begin
        hit           = 1'b1;
        hit_idx       = SELW'(i);
        hit_onehot    = '0;
        hit_onehot[i] = 1'b1;
        hit_wait      = SLOT_WAIT[i*3 +: 3];
        hit_ready     = slv_ready[i];
      end else begin
        hit = hit;
      end
    end
  end

  // Access sequencing: next state, wait counter and CPU/slave handshakes.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    rdy        = 1'b1;
    cs_en      = 1'b0;
    we_en      = 1'b0;
    timeout    = 1'b0;
    if (reset) begin
      state_next = ST_IDLE;
      cnt_next   = 8'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          cs_en = hit;
          if (!hit) begin
            state_next = ST_IDLE;
          end else if (hit_wait == 3'd0) begin
            we_en = cpu_we;
          end else if (hit_wait == WAIT_PACED) begin
            cnt_next = 8'd0;
            rdy      = hit_ready;
            if (hit_ready) begin
              we_en = cpu_we;
            end else begin
              state_next = ST_PACE;
            end
          end else begin
            rdy        = 1'b0;
            cnt_next   = 8'(hit_wait) - 8'd1;
            state_next = ST_WAIT;
          end
        end
        ST_WAIT: begin
          cs_en = hit;
          if (!hit) begin
            state_next = ST_IDLE;
          end else if (cnt != 8'd0) begin
            rdy      = 1'b0;
            cnt_next = cnt - 8'd1;
          end else begin
            we_en      = cpu_we;
            state_next = ST_IDLE;
          end
        end
        ST_PACE: begin
          cs_en = hit;
          if (!hit) begin
            state_next = ST_IDLE;
          end else if (hit_ready) begin
            we_en      = cpu_we;
            state_next = ST_IDLE;
          end else if (cnt == CNT_LAST) begin
            // Slave never answered: release the CPU, drop the write, fault.
            timeout    = 1'b1;
            state_next = ST_IDLE;
          end else begin
            rdy      = 1'b0;
            cnt_next = cnt + 8'd1;
          end
        end
        default: begin
          state_next = ST_IDLE;
          cnt_next   = 8'd0;
        end
      endcase
    end
  end

  // FSM state and wait counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Remember which slot was addressed so its registered data is returned next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q <= SEL_MISS;
    end else if (timeout) begin
      sel_q <= SEL_MISS;
    end else begin
      sel_q <= hit_idx;
    end
  end

  // Read data mux; anything without a live slot reads as 8'hFF.
  always_comb begin
    cpu_di = 8'hFF;
    for (int i = 0; i < NSLOT; i++) begin
      if (sel_q == SELW'(i)) begin
        cpu_di = slv_rdata[i*8 +: 8];
      end else begin
        cpu_di = cpu_di;
      end
    end
  end

  // Sticky fault flag; the address is kept from the first fault after a clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      fault      <= 1'b0;
      fault_addr <= 16'h0000;
    end else if (fault_set) begin
      fault <= 1'b1;
      if (!fault || fault_clr) begin
        fault_addr <= cpu_ab;
      end else begin
        fault_addr <= fault_addr;
      end
    end else if (fault_clr) begin
      fault <= 1'b0;
    end else begin
      fault <= fault;
    end
  end

endmodule
